// File: rtl/led_blink_bank.sv
// led_blink_bank
//   A bank of independent LED channels. Each channel is set up by a
//   single write and then runs in one of four modes: OFF, ON, BLINK
//   (square wave, half-period = period+1 cycles) or ONESHOT (high for
//   period+1 cycles, then drops to OFF and pulses done once).
//
// Ports
//   CLOCK_50    system clock, all logic on its rising edge
//   reset       asynchronous active-high reset
//   run         global enable; 0 freezes every counter and LED state
//   cfg_we      one-cycle configuration write strobe
//   cfg_ch      channel targeted by the write
//   cfg_mode    00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_period  terminal count for BLINK/ONESHOT
//   LED         channel outputs, inverted when ACTIVE_LOW != 0
//   done        one-cycle pulse per channel when a ONESHOT completes
//   cfg_err     one-cycle pulse when a write targets a missing channel
module led_blink_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 33,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  done,
  output logic             cfg_err
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [N_CH-1:0] state;
  logic            ch_valid;

  // cfg_ch is zero-extended so N_CH = 16 still compares correctly.
  assign ch_valid = ({1'b0, cfg_ch} < 5'(N_CH));

  // Error pulse for writes aimed past the last implemented channel.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !ch_valid;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(i);

    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             state_q;
    logic             done_q;
    logic             hit;
    logic             terminal;

    assign hit      = cfg_we && (cfg_ch == CH_IDX);
    // Comparing for equality and clearing on match means the counter
    // never exceeds period, so an all-ones period cannot overflow.
    assign terminal = (cnt == period);

    // A write always takes priority over the running count, so a write
    // landing on the terminal cycle suppresses both toggle and done.
    // The initial state for each mode happens to equal cfg_mode[0].
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        mode    <= MODE_OFF;
        period  <= '0;
        cnt     <= '0;
        state_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (hit) begin
          mode    <= cfg_mode;
          period  <= cfg_period;
          cnt     <= '0;
          state_q <= cfg_mode[0];
        end else if (run) begin
          case (mode)
            MODE_BLINK: begin
              if (terminal) begin
                cnt     <= '0;
                state_q <= ~state_q;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            MODE_ONESHOT: begin
              if (terminal) begin
                cnt     <= '0;
                state_q <= 1'b0;
                mode    <= MODE_OFF;
                done_q  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            MODE_ON,
            MODE_OFF: begin
              cnt <= '0;
            end
            default: begin
              cnt <= '0;
            end
          endcase
        end
      end
    end

    assign state[i] = state_q;
    assign done[i]  = done_q;
  end

  assign LED = state ^ {N_CH{(ACTIVE_LOW != 0)}};

endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank
//   Drives two copies of the LED bank (active-high and active-low) with
//   the same directed and random stimulus and compares them every cycle
//   against a model that tracks, per channel, how many running cycles
//   have elapsed since its last configuration write.
module tb_led_blink_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 33;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic             CLOCK_50;
  logic             reset;
  logic             run;
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  done_o;
  logic             cfg_err;
  logic [N_CH-1:0]  led_al;
  logic [N_CH-1:0]  done_al;
  logic             cfg_err_al;

  int checks = 0;
  int errors = 0;

  // Model: per-channel configuration plus elapsed running cycles.
  int     m_mode [N_CH];
  longint m_per  [N_CH];
  longint m_e    [N_CH];
  bit     m_ran  [N_CH];
  bit     m_err;

  led_blink_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .ACTIVE_LOW(0)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .LED(led), .done(done_o), .cfg_err(cfg_err)
  );

  led_blink_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .ACTIVE_LOW(1)) dut_al (
    .CLOCK_50(CLOCK_50), .reset(reset), .run(run), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .LED(led_al), .done(done_al), .cfg_err(cfg_err_al)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // BLINK: level flips every period+1 running cycles, starting low.
  // ONESHOT: high for the first period+1 running cycles, low after.
  function automatic logic exp_level(int i);
    longint h;
    h = m_per[i] + 1;
    case (m_mode[i])
      1:       return 1'b1;
      2:       return ((m_e[i] / h) % 2) == 1;
      3:       return m_e[i] < h;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [N_CH-1:0] exp_led();
    logic [N_CH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) v[i] = exp_level(i);
    return v;
  endfunction

  // done appears only on the cycle the elapsed count first reaches period+1.
  function automatic logic [N_CH-1:0] exp_done();
    logic [N_CH-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++)
      v[i] = (m_mode[i] == 3) && m_ran[i] && (m_e[i] == m_per[i] + 1);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0;
      m_per[i]  = 0;
      m_e[i]    = 0;
      m_ran[i]  = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    m_err = cfg_we && (int'(cfg_ch) >= N_CH);
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_mode[i] = int'(cfg_mode);
        m_per[i]  = longint'(cfg_period);
        m_e[i]    = 0;
        m_ran[i]  = 1'b0;
      end else if (run) begin
        m_e[i]   = m_e[i] + 1;
        m_ran[i] = 1'b1;
      end else begin
        m_ran[i] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [N_CH-1:0] el;
    logic [N_CH-1:0] ed;
    el = exp_led();
    ed = exp_done();
    checks++;
    assert (led === el) else begin
      errors++;
      $error("[TB] FAIL %s led: observed %b expected %b", tag, led, el);
    end
    checks++;
    assert (led_al === ~el) else begin
      errors++;
      $error("[TB] FAIL %s led_al: observed %b expected %b", tag, led_al, ~el);
    end
    checks++;
    assert (done_o === ed) else begin
      errors++;
      $error("[TB] FAIL %s done: observed %b expected %b", tag, done_o, ed);
    end
    checks++;
    assert (done_al === ed) else begin
      errors++;
      $error("[TB] FAIL %s done_al: observed %b expected %b", tag, done_al, ed);
    end
    checks++;
    assert (cfg_err === m_err && cfg_err_al === m_err) else begin
      errors++;
      $error("[TB] FAIL %s cfg_err: observed %b/%b expected %b", tag, cfg_err, cfg_err_al, m_err);
    end
  endtask

  // Inputs change just after a falling edge, outputs are checked on the next one.
  task automatic applyStimulus(input logic r, input logic ru, input logic we,
                               input logic [3:0] ch, input logic [1:0] md,
                               input logic [CNT_W-1:0] per, input string tag);
    reset      = r;
    run        = ru;
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_mode   = md;
    cfg_period = per;
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input logic ru, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, ru, 1'b0, 4'd0, M_OFF, '0, tag);
  endtask

  initial begin
    logic [CNT_W-1:0] max_per;
    max_per    = '1;
    reset      = 1'b1;
    run        = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = 4'd0;
    cfg_mode   = M_OFF;
    cfg_period = '0;
    model_reset();
    @(negedge CLOCK_50);
    checkOutput("reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, M_OFF, '0, "reset_hold");

    // Channel 0 blink, half-period of five cycles.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, M_BLINK, 33'd4, "wr_ch0_blink");
    idle(22, 1'b1, "blink_ch0");

    // Channel 2 oneshot, ten cycles high then done.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, M_ONESHOT, 33'd9, "wr_ch2_oneshot");
    idle(14, 1'b1, "oneshot_ch2");

    // Channel 1 blink frozen mid-count, then resumed.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, M_BLINK, 33'd2, "wr_ch1_blink");
    idle(2, 1'b1, "blink_ch1");
    idle(7, 1'b0, "frozen");
    idle(8, 1'b1, "resumed");

    // Write to a missing channel.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd4, M_ON, '0, "bad_ch");
    idle(2, 1'b1, "after_bad_ch");

    // Channel 3 rewritten on its terminal cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, M_BLINK, 33'd3, "wr_ch3_blink");
    idle(3, 1'b1, "ch3_count");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, M_BLINK, 33'd5, "ch3_terminal_write");
    idle(8, 1'b1, "ch3_new_cfg");

    // Channel 0 blink with period 0 toggles every cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, M_BLINK, 33'd0, "wr_ch0_p0");
    idle(6, 1'b1, "ch0_p0");

    // Largest period: counter must not wrap early.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd1, M_BLINK, max_per, "wr_ch1_max");
    idle(5, 1'b1, "ch1_max");

    // Asynchronous reset mid-oneshot.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, M_ONESHOT, 33'd20, "wr_ch2_long");
    idle(5, 1'b1, "ch2_long");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checkOutput("async_reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, M_OFF, '0, "in_reset");
    idle(25, 1'b1, "after_reset");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, ru, we;
      logic [3:0] ch;
      logic [1:0] md;
      logic [CNT_W-1:0] per;
      r   = ($urandom_range(0, 99) == 0);
      ru  = ($urandom_range(0, 4) != 0);
      we  = ($urandom_range(0, 3) == 0);
      ch  = 4'($urandom_range(0, 4));
      md  = 2'($urandom_range(0, 3));
      per = CNT_W'($urandom_range(0, 6));
      applyStimulus(r, ru, we, ch, md, per, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 33, width of per-channel period counter and cfg_period.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, every LED output bit is driven as the inverse of its internal channel state.
REQ-004 SHALL have port CLOCK_50  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  input  1  global enable; 0 freezes all counters and LED states.
REQ-007 SHALL have port cfg_we  input  1  one-cycle configuration write strobe.
REQ-008 SHALL have port cfg_ch  input  4  target channel index for the write.
REQ-009 SHALL have port cfg_mode  input  2  mode code: 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
REQ-010 SHALL have port cfg_period  input  CNT_W  terminal count for BLINK/ONESHOT.
REQ-011 SHALL have port LED  output  N_CH  registered channel outputs, polarity per ACTIVE_LOW.
REQ-012 SHALL have port done  output  N_CH  one-cycle pulse per channel when a ONESHOT completes.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse when a write targets cfg_ch >= N_CH.

Function
REQ-014 Each channel SHALL hold registered mode, period, counter and state bit; LED[i] = state[i] XOR ACTIVE_LOW.
REQ-015 On cfg_we with cfg_ch < N_CH, the channel SHALL latch mode and period, clear its counter to 0, and load state (OFF 0, ON 1, BLINK 0, ONESHOT 1), all visible on the next cycle.
REQ-016 On cfg_we with cfg_ch >= N_CH, no channel SHALL change and cfg_err SHALL pulse high on the next cycle.
REQ-017 A configuration write SHALL take effect regardless of run.
REQ-018 OFF and ON SHALL hold state constant; counter stays 0.
REQ-019 BLINK with run=1: counter increments 0..period; on the cycle counter == period, state toggles and counter returns to 0, giving half-period = period+1 cycles.
REQ-020 BLINK with period 0 SHALL toggle every cycle.
REQ-021 ONESHOT with run=1: state stays 1 while counter counts 0..period; on counter == period, state goes 0, mode becomes OFF, counter clears, done[i] pulses high for exactly one cycle.
REQ-022 Counter SHALL never exceed period; at period = 2^CNT_W-1 it SHALL wrap to 0 without overflow artefacts.
REQ-023 With run=0, counters, states and modes SHALL hold; done SHALL not pulse.
REQ-024 A write to channel i in the same cycle channel i reaches terminal count SHALL win: no toggle, no done pulse, new configuration loaded.
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL not disturb another's counter or phase.

Reset
REQ-026 reset high SHALL immediately, independent of CLOCK_50, set all modes OFF, periods 0, counters 0, states 0, done 0, cfg_err 0.
REQ-027 During reset, LED SHALL read all-0 (ACTIVE_LOW=0) or all-1 (ACTIVE_LOW=1).
REQ-028 Reset asserted mid-blink or mid-oneshot SHALL abort the operation with no done pulse; after release, operation resumes only after a new write.

Verification
REQ-029 Reset pulse, run=1, write ch0 BLINK period=4 -> LED[0] toggles every 5 cycles starting at 0; other LEDs remain 0.
REQ-030 Write ch2 ONESHOT period=9 -> LED[2]=1 for 10 cycles, then 0; done[2] high exactly one cycle at the falling transition; channel mode reads OFF thereafter.
REQ-031 Blink ch1 period=2, drop run for 7 cycles mid-count -> LED[1] and phase frozen; after run=1 the remaining count completes unchanged.
REQ-032 Write with cfg_ch=N_CH (4) -> cfg_err pulses one cycle, all LEDs unchanged; write to ch3 at its terminal cycle -> new mode applied, no toggle.
REQ-033 Assert reset asynchronously between clock edges during an active ONESHOT -> LED drops to 0 immediately, done never pulses.
REQ-034 ACTIVE_LOW=1 build, ch0 BLINK period=0 -> LED[0] toggles every cycle starting at 1; under reset all LEDs read 1.
